data_memory_pipe: RTL and testbench

//   Parametrised, pipelined data memory for the MEM stage; successor to the flat 128-word data memory.
//   - Valid/ready request port: one load or store accepted per cycle.
//   - Byte, half and word accesses, with sign or zero extension on loads.
//   - Programmable read latency.
//   - Misalignment detection.
//   - Post-reset initialisation sweep; no combinational clear of the array.

---
 rtl/data_memory_pipe.sv | 167 ++++++++++++++++
 tb/tb_data_memory_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_pipe.sv
// ============================================================================
// data_memory_pipe : pipelined MEM-stage data memory with byte/half/word
//                    access, post-reset init sweep and RD_LAT response pipe.
// Optional feature macro: DMEM_BOUNDS_CHECK_EN (flag addresses >= DEPTH*4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module data_memory_pipe #(
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 128,
    parameter int RD_LAT     = 1,
    parameter int INIT_WORDS = 8
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int c_idx_w = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_sweep;
    logic [31:0]          r_mem [DEPTH];

    logic                 r_pv   [RD_LAT];
    logic [31:0]          r_prd  [RD_LAT];
    logic                 r_perr [RD_LAT];

    logic                 w_accept;
    logic [c_idx_w-1:0]   w_idx;
    logic [1:0]           w_off;
    logic                 w_misalign;
    logic                 w_oob;
    logic                 w_err;
    logic [3:0]           w_be;
    logic [31:0]          w_lanes;
    logic [31:0]          w_word;
    logic [31:0]          w_shift;
    logic [31:0]          w_load;
    logic [31:0]          w_rdata;

    assign w_accept = req_valid & req_ready;
    assign w_idx    = req_addr[c_idx_w+1:2];
    assign w_off    = req_addr[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_oob = (req_addr >> (c_idx_w + 2)) != '0;
`else
    // Upper address bits are deliberately ignored so the space wraps.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[ADDR_W-1:c_idx_w+2]};
    assign w_oob         = 1'b0;
`endif

    // Store data is replicated across lanes so the byte enables pick the right copy.
    always_comb begin
        w_misalign = 1'b0;
        w_be       = 4'b0000;
        w_lanes    = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_lanes = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_misalign = w_off[0];
                w_be       = 4'b0011 << w_off;
                w_lanes    = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_misalign = (w_off != 2'b00);
                w_be       = 4'b1111;
            end
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_err   = w_misalign | w_oob;
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_off, 3'b000};

    always_comb begin
        w_load = w_word;
        case (req_size)
            2'b00:   w_load = req_signed ? {{24{w_shift[7]}}, w_shift[7:0]}
                                         : {24'h000000, w_shift[7:0]};
            2'b01:   w_load = req_signed ? {{16{w_shift[15]}}, w_shift[15:0]}
                                         : {16'h0000, w_shift[15:0]};
            default: w_load = w_word;
        endcase
    end

    assign w_rdata = (req_write | w_err) ? 32'h0 : w_load;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_state   <= ST_INIT;
            r_sweep   <= '0;
            req_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == '1) begin
                        r_state   <= ST_RUN;
                        req_ready <= 1'b1;
                    end
                end
                default: req_ready <= 1'b1;
            endcase
        end
    end

    // Array has no reset; contents are rebuilt by the sweep instead.
    always_ff @(posedge clock_in) begin
        if (r_state == ST_INIT) begin
            r_mem[r_sweep] <= (32'(r_sweep) < INIT_WORDS) ? 32'(r_sweep) : 32'h0;
        end else if (w_accept && req_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_pv[k]   <= 1'b0;
                r_prd[k]  <= 32'h0;
                r_perr[k] <= 1'b0;
            end
        end else begin
            r_pv[0]   <= w_accept;
            r_prd[0]  <= w_accept ? w_rdata : 32'h0;
            r_perr[0] <= w_accept & w_err;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pv[k]   <= r_pv[k-1];
                r_prd[k]  <= r_prd[k-1];
                r_perr[k] <= r_perr[k-1];
            end
        end
    end

    assign rsp_valid = r_pv[RD_LAT-1];
    assign rsp_rdata = r_prd[RD_LAT-1];
    assign rsp_err   = r_perr[RD_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_data_memory_pipe.sv
// ============================================================================
// tb_data_memory_pipe : directed + random checks of data_memory_pipe at
//                       RD_LAT=1 and RD_LAT=3 against a byte-array model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_pipe;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        ready1, ready3;
    logic        rsp_valid1, rsp_valid3;
    logic [31:0] rsp_rdata1, rsp_rdata3;
    logic        rsp_err1, rsp_err3;

    data_memory_pipe #(.ADDR_W(32), .DEPTH(DEPTH), .RD_LAT(1), .INIT_WORDS(8)) u_dut1 (
        .clock_in(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    data_memory_pipe #(.ADDR_W(32), .DEPTH(DEPTH), .RD_LAT(3), .INIT_WORDS(8)) u_dut3 (
        .clock_in(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready3),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  mm [DEPTH*4];
    bit          ev1, ev3;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory kept as a flat little-endian byte array.
    function automatic void model_init();
        for (int i = 0; i < DEPTH * 4; i++) mm[i] = 8'h00;
        for (int i = 0; i < 8; i++) mm[i*4] = 8'(i);
    endfunction

    function automatic void model_op(input logic wr, input logic [1:0] sz, input logic sg,
                                     input logic [31:0] addr, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        longint a;
        int     nb, off, base;
        logic [63:0] v;
        a    = longint'(addr);
        off  = int'(a % 4);
        base = int'(((a / 4) % DEPTH) * 4);
        nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er   = (sz == 2'd3) || ((off % nb) != 0);
`ifdef DMEM_BOUNDS_CHECK_EN
        if (a >= DEPTH * 4) er = 1'b1;
`endif
        rd = 32'h0;
        if (!er) begin
            if (wr) begin
                for (int b = 0; b < nb; b++) mm[base + off + b] = 8'((wd >> (8 * b)) & 32'hFF);
            end else begin
                v = 64'h0;
                for (int b = 0; b < nb; b++) v = v + (64'(mm[base + off + b]) << (8 * b));
                if (sg && v >= (64'h1 << (8 * nb - 1))) v = v - (64'h1 << (8 * nb));
                rd = v[31:0];
            end
        end
    endfunction

    always @(negedge clk) begin
        while (q1.size() > 0 && q1[0].due < cyc) void'(q1.pop_front());
        ev1 = (q1.size() > 0 && q1[0].due == cyc);
        chk("rsp_valid_lat1", {31'b0, rsp_valid1}, {31'b0, ev1});
        if (ev1 && rsp_valid1 === 1'b1) begin
            chk("rdata_lat1", rsp_rdata1, q1[0].rd);
            chk("err_lat1", {31'b0, rsp_err1}, {31'b0, q1[0].err});
            void'(q1.pop_front());
        end
    end

    always @(negedge clk) begin
        while (q3.size() > 0 && q3[0].due < cyc) void'(q3.pop_front());
        ev3 = (q3.size() > 0 && q3[0].due == cyc);
        chk("rsp_valid_lat3", {31'b0, rsp_valid3}, {31'b0, ev3});
        if (ev3 && rsp_valid3 === 1'b1) begin
            chk("rdata_lat3", rsp_rdata3, q3[0].rd);
            chk("err_lat3", {31'b0, rsp_err3}, {31'b0, q3[0].err});
            void'(q3.pop_front());
        end
    end

    // Drive one request; it is accepted at the next posedge.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit use_exp, input logic [31:0] erd, input logic eer);
        logic [31:0] mrd;
        logic        mer;
        exp_t        e;
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        model_op(wr, sz, sg, addr, wd, mrd, mer);
        e.rd  = use_exp ? erd : mrd;
        e.err = use_exp ? eer : mer;
        e.due = cyc + 1;
        q1.push_back(e);
        e.due = cyc + 3;
        q3.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (ready1 === 1'b1) break;
            n++;
        end
        chk("init_ready_low_cycles", n, 128);
        chk("ready_lat3", {31'b0, ready3}, 32'h1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        q1.delete();
        q3.delete();
        model_init();
        #1;
        chk("reset_rsp_valid1", {31'b0, rsp_valid1}, 32'h0);
        chk("reset_rsp_valid3", {31'b0, rsp_valid3}, 32'h0);
        chk("reset_rdata3", rsp_rdata3, 32'h0);
        chk("reset_err3", {31'b0, rsp_err3}, 32'h0);
        chk("reset_ready1", {31'b0, ready1}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        wait_ready();
    endtask

    initial begin
        logic [31:0] a;
        do_reset();

        // Initial contents after the sweep
        do_req(1'b0, 2'd2, 1'b0, 32'h0,  32'h0, 1, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, 1, 32'h7, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1, 32'h0, 1'b0);
        idle();

        // Lane writes and extended loads
        do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, 1, 32'h0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000AA, 1, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1, 32'h1122AA44, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h41, 32'h0, 1, 32'hFFFFFFAA, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1, 32'h00001122, 1'b0);

        // Misalignment and illegal size
        do_req(1'b1, 2'd1, 1'b0, 32'h43, 32'h0000BEEF, 1, 32'h0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1, 32'h0, 1'b1);
        do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1, 32'h0, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1, 32'h1122AA44, 1'b0);
        idle();

        // Back-to-back loads through both pipelines
        do_req(1'b0, 2'd2, 1'b0, 32'h4,  32'h0, 1, 32'h1, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h8,  32'h0, 1, 32'h2, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'hC,  32'h0, 1, 32'h3, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1, 32'h4, 1'b0);
        idle();

        // Address beyond DEPTH*4
`ifdef DMEM_BOUNDS_CHECK_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h208, 32'h0, 1, 32'h0, 1'b1);
`else
        do_req(1'b0, 2'd2, 1'b0, 32'h208, 32'h0, 1, 32'h2, 1'b0);
`endif
        idle();

        // Store followed immediately by a load of the same word
        do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D, 1, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, 1, 32'hFFFFCAFE, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            a = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 15)) * 4
                + $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FE00);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, 0, 32'h0, 1'b0);
        end
        idle();
        repeat (5) @(posedge clk);

        // Reset with loads in flight
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 0, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0, 32'h0, 1'b0);
        do_reset();
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1, 32'h5, 1'b0);
        idle();
        repeat (6) @(posedge clk);
        #1;
        chk("drain_q_lat1", q1.size(), 32'h0);
        chk("drain_q_lat3", q3.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
